uart_frame_sender: RTL
======================

# uart_frame_sender

Frame-level sequencer for the UART transmit path. On a start pulse it streams one camera frame out of the frame-buffer read port: two sync bytes, then FRAME_BYTES payload bytes, then an optional checksum byte. It drives the `uart_tx` byte interface (`data_valid`/`busy`) one byte at a time. At top level it sits between the frame buffer and `uart_tx`.

## Interface
- FRAME_BYTES, 19200: payload bytes per frame (160x120 x 8 bit); must be ≥1 and ≤ 2^ADDR_W.
- ADDR_W, 15: frame-buffer address width.
- SYNC0, 8'hAA: first header byte.
- SYNC1, 8'h55: second header byte.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to send one frame; ignored while frame_busy.
- abort  in  1  level; terminates the frame at the next byte boundary.
- mem_rd_en  out  1  frame-buffer read strobe, one cycle.
- mem_addr  out  ADDR_W  payload byte address, 0..FRAME_BYTES-1.
- mem_rd_data  in  8  read data, valid the cycle after mem_rd_en.
- tx_data  out  8  byte to `uart_tx` data_in.
- tx_valid  out  1  one-cycle pulse to `uart_tx` data_valid.
- tx_busy  in  1  `uart_tx` busy.
- frame_busy  out  1  high from the cycle after start is accepted until return to IDLE.
- frame_done  out  1  one-cycle pulse after the last byte has fully left the line.

## Operation
- States: IDLE, FETCH, LATCH, ISSUE, ACCEPT, DRAIN, DONE.
- Phase register: HDR0, HDR1, PAYLOAD, CKSUM. The payload index counts 0..FRAME_BYTES-1.
- **IDLE:** If start=1 and abort=0, clear index, mem_addr and checksum, set phase=HDR0, and go to FETCH.
- **FETCH:** Assert mem_rd_en only when phase=PAYLOAD, with mem_addr=index. Then go to LATCH.
- **LATCH:** Load tx_data according to phase:
  - HDR0: SYNC0.
  - HDR1: SYNC1.
  - PAYLOAD: mem_rd_data, and checksum += mem_rd_data mod 256.
  - CKSUM: the checksum.
  Then go to ISSUE.
- **ISSUE:** tx_valid=1 for this cycle only. Then go to ACCEPT.
- **ACCEPT:** Wait one cycle, because `uart_tx` busy is registered and goes high one cycle after data_valid. Then go to DRAIN.
- **DRAIN:** Wait for tx_busy=0, then advance the phase:
  - HDR0 → HDR1.
  - HDR1 → PAYLOAD.
  - PAYLOAD: increment index. When the last index has been sent, go to CKSUM (if enabled) or DONE.
  - CKSUM → DONE.
  Otherwise go to FETCH.
- **DONE:** Pulse frame_done, then go to IDLE.
- **Abort:**
  - Sampled in FETCH or LATCH: go to IDLE immediately, with no tx_valid.
  - Sampled in ISSUE, ACCEPT or DRAIN: the current byte completes, then go to IDLE.
  - frame_done is never pulsed for an aborted frame.
- start and abort high together in IDLE: abort wins and the FSM stays in IDLE.
- start while frame_busy: ignored, with no queuing.
- tx_data holds its value from LATCH until the next LATCH.

## Timing
- Reset values: tx_valid=0, tx_data=0, mem_rd_en=0, mem_addr=0, frame_busy=0, frame_done=0. The FSM is in IDLE and phase=HDR0.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- start sampled at edge k: FETCH in cycle k+1, tx_valid in cycle k+3.
- tx_busy sampled 0 in DRAIN at edge m: next tx_valid in cycle m+3.
- mem_rd_en in cycle n: mem_rd_data is captured at the end of cycle n+1.
- Exactly one tx_valid pulse per byte. tx_valid is never asserted while tx_busy=1.
- frame_done is 1 cycle after the final DRAIN exit. frame_busy falls together with the return to IDLE.
- Reset mid-frame clears everything immediately; any partial UART byte is the responsibility of `uart_tx` reset.

## Configuration
- `UART_FRAME_CHECKSUM_EN` defined: after the payload, send one byte equal to the 8-bit sum (mod 256) of all payload bytes. The header is excluded.
- Not defined: the CKSUM phase and the accumulator are absent, and the frame ends after the last payload byte.

## Structure
- Package `uart_frame_pkg`: state encoding constants, phase encoding constants, default SYNC0/SYNC1 values.
- No sub-module. `uart_tx` is instantiated alongside at top level, not inside this block.

## Test plan
- FRAME_BYTES=4, memory 01 02 03 FF, CLK_FREQ=1 MHz, BAUD=100 kbaud, macro on → line bytes AA 55 01 02 03 FF 05, then a single frame_done.
- Same config, macro off → AA 55 01 02 03 FF, with frame_done one cycle after the FF stop bit ends.
- start pulsed again mid-frame → no extra bytes, frame identical to the first case.
- abort raised during payload byte 02 (DRAIN) → byte 02 completes, no further tx_valid, frame_done stays 0, frame_busy falls.
- start and abort high together in IDLE → FSM stays in IDLE, tx_valid stays 0. Then start alone → a full frame is sent.
- rst_n low during byte 01 → all outputs return to reset values asynchronously. A subsequent start sends a complete frame beginning with AA.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared encodings for the UART frame sender: FSM states,
// frame phases and default sync header bytes.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_ISSUE  = 3'd3,
        S_ACCEPT = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PH_HDR0    = 2'd0,
        PH_HDR1    = 2'd1,
        PH_PAYLOAD = 2'd2,
        PH_CKSUM   = 2'd3
    } phase_t;

    localparam logic [7:0] SYNC0_DEF = 8'hAA;
    localparam logic [7:0] SYNC1_DEF = 8'h55;

endpackage

// File: rtl/uart_frame_sender.sv
// Streams sync header, frame payload and optional checksum to uart_tx.
// Define UART_FRAME_CHECKSUM_EN to append the mod-256 payload checksum.
module uart_frame_sender
    import uart_frame_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = 19200,
    parameter int unsigned ADDR_W      = 15,
    parameter logic [7:0]  SYNC0       = SYNC0_DEF,
    parameter logic [7:0]  SYNC1       = SYNC1_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    output logic              frame_busy,
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_BYTES - 1);

    state_t            state;
    state_t            state_nxt;
    phase_t            phase;
    logic [ADDR_W-1:0] index;
    logic              abort_pend;
    logic              last_byte;

`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0] cksum;
    assign last_byte = (phase == PH_CKSUM);
`else
    assign last_byte = (phase == PH_PAYLOAD) && (index == LAST_IDX);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start && !abort) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                state_nxt = abort ? S_IDLE : S_LATCH;
            end
            S_LATCH: begin
                state_nxt = abort ? S_IDLE : S_ISSUE;
            end
            S_ISSUE: begin
                state_nxt = S_ACCEPT;
            end
            S_ACCEPT: begin
                state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!tx_busy) begin
                    if (abort || abort_pend) state_nxt = S_IDLE;
                    else if (last_byte)      state_nxt = S_DONE;
                    else                     state_nxt = S_FETCH;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign tx_valid   = (state == S_ISSUE);
    assign mem_rd_en  = (state == S_FETCH) && (phase == PH_PAYLOAD);
    assign mem_addr   = index;
    assign frame_busy = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= PH_HDR0;
            index      <= '0;
            tx_data    <= 8'h00;
            abort_pend <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            cksum      <= 8'h00;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    abort_pend <= 1'b0;
                    if (start && !abort) begin
                        phase <= PH_HDR0;
                        index <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                        cksum <= 8'h00;
`endif
                    end
                end
                S_LATCH: begin
                    if (!abort) begin
                        unique case (phase)
                            PH_HDR0: tx_data <= SYNC0;
                            PH_HDR1: tx_data <= SYNC1;
                            PH_PAYLOAD: begin
                                tx_data <= mem_rd_data;
`ifdef UART_FRAME_CHECKSUM_EN
                                cksum   <= cksum + mem_rd_data;
`endif
                            end
                            PH_CKSUM: begin
`ifdef UART_FRAME_CHECKSUM_EN
                                tx_data <= cksum;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                S_ISSUE, S_ACCEPT: begin
                    if (abort) abort_pend <= 1'b1;
                end
                S_DRAIN: begin
                    if (abort) abort_pend <= 1'b1;
                    // Index stays at the last address so mem_addr never leaves range
                    if (!tx_busy) begin
                        unique case (phase)
                            PH_HDR0: phase <= PH_HDR1;
                            PH_HDR1: phase <= PH_PAYLOAD;
                            PH_PAYLOAD: begin
                                if (index != LAST_IDX) begin
                                    index <= index + 1'b1;
                                end else begin
`ifdef UART_FRAME_CHECKSUM_EN
                                    phase <= PH_CKSUM;
`endif
                                end
                            end
                            PH_CKSUM: ;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
